// File: rtl/uart_receiver.sv
// 8N1 UART receiver: a 2-flop synchronizer feeds a mid-bit sampling FSM.
// Each byte is presented with a one-cycle data_valid strobe; a low stop bit gives frame_error.
`timescale 1ns/1ps
module uart_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_waveform,
  output logic [DATA_BITS-1:0] data_received,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [2:0]           bit_idx, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt, dout_nxt;
  logic                 dv_nxt, fe_nxt;
  logic                 rx_meta, rx_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      data_received <= '0;
      data_valid    <= 1'b0;
      frame_error   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      rx_meta       <= rx_waveform;
      rx_sync       <= rx_meta;
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bit_idx       <= bit_nxt;
      shift         <= shift_nxt;
      data_received <= dout_nxt;
      data_valid    <= dv_nxt;
      frame_error   <= fe_nxt;
      busy          <= (state_nxt != IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    dout_nxt  = data_received;
    dv_nxt    = 1'b0;
    fe_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_sync) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        // Re-check mid start bit; a line already high again was only a glitch.
        if (cnt == CNT_MID) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rx_sync ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          shift_nxt[bit_idx] = rx_sync;
          cnt_nxt            = '0;
          bit_nxt            = bit_idx + 3'd1;
          if (bit_idx == BIT_LAST) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        // Leaving mid stop bit lets a back-to-back start bit be caught.
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (rx_sync) begin
            dout_nxt  = shift;
            dv_nxt    = 1'b1;
            state_nxt = IDLE;
          end else begin
            fe_nxt    = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_sync) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
